// File: rtl/seg_dynamic.sv
// seg_dynamic: taxi-meter display back-end.
// Saturates the 20-bit fare and converts it to six BCD digits with a sequential
// double-dabble engine. The digits are scanned onto a six-digit common-anode
// 7-segment module, with leading-zero blanking, an optional minus sign and
// per-digit decimal points.
module seg_dynamic #(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] price,
    input  logic [5:0]  point,
    input  logic        seg_en,
    input  logic        sign,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [4:0] SHIFT_LAST = 5'd19;
    localparam logic [2:0] IDX_LAST   = 3'd5;

    // Anything above the six-digit range is shown as all nines.
    function automatic logic [19:0] sat_price(input logic [19:0] p);
        return (p > 20'd999_999) ? 20'd999_999 : p;
    endfunction

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    function automatic logic [23:0] add3_nibbles(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < 6; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    state_t      r_state;
    logic [4:0]  r_shift_cnt;
    logic [19:0] r_bin;
    logic [23:0] r_bcd;
    logic [23:0] r_disp_bcd;
    logic [15:0] r_scan_cnt;
    logic [2:0]  r_idx;

    logic [23:0] w_bcd_adj;
    logic        w_tick;
    logic [2:0]  w_high;
    logic [3:0]  w_nib;
    logic [7:0]  w_glyph;

    assign w_bcd_adj = add3_nibbles(r_bcd);
    assign w_tick    = (r_scan_cnt == CNT_MAX);

    // ---- conversion control: IDLE -> LOAD -> SHIFT x20 -> DONE -> LOAD ----
    // Converter sequencing; the display register changes only when a pass completes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_shift_cnt <= '0;
            r_disp_bcd  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift_cnt <= '0;
                    r_state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_shift_cnt == SHIFT_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    r_disp_bcd <= r_bcd;
                    r_state    <= S_LOAD;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- conversion datapath ----
    // Binary/BCD shift pair; price is sampled only at LOAD so mid-pass changes wait a pass.
    always_ff @(posedge sys_clk) begin
        case (r_state)
            S_LOAD: begin
                r_bin <= sat_price(price);
                r_bcd <= '0;
            end
            S_SHIFT: begin
                {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
            end
            default: begin
                r_bin <= r_bin;
                r_bcd <= r_bcd;
            end
        endcase
    end

    // ---- scan timing ----
    // Dwell counter and digit index; idx advances once per counter wrap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (w_tick) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
        end
    end

    // Position of the most significant nonzero digit (0 when the value is 0).
    always_comb begin
        w_high = 3'd0;
        for (int i = 1; i < 6; i++) begin
            if (r_disp_bcd[4*i +: 4] != 4'd0) begin
                w_high = 3'(i);
            end
        end
    end

    // Glyph of the digit under scan: number, minus just left of the number, or blank.
    always_comb begin
        w_nib   = r_disp_bcd[{r_idx, 2'b00} +: 4];
        w_glyph = 8'hFF;
        if (r_idx <= w_high) begin
            w_glyph = glyph(w_nib);
        end else if (sign && (r_idx == w_high + 3'd1)) begin
            w_glyph = 8'hBF;
        end
        if (point[r_idx]) begin
            w_glyph[7] = 1'b0;
        end
    end

    // ---- output stage ----
    // Registered digit drive so sel and seg always change on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel <= 6'b000000;
            seg <= 8'hFF;
        end else if (seg_en) begin
            sel <= 6'b000001 << r_idx;
            seg <= w_glyph;
        end else begin
            sel <= 6'b000000;
            seg <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg_dynamic.sv
// Testbench for seg_dynamic with a fast scan (CNT_MAX = 4): directed scenarios
// plus randomized fares compared against a decimal-arithmetic display model.
module tb_seg_dynamic;

    localparam int CNT = 4;
    localparam int DWELL = CNT + 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [19:0] price;
    logic [5:0]  point;
    logic        seg_en;
    logic        sign;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [7:0] obs_seg [6];
    logic [5:0] obs_seen;
    logic [7:0] exp_tab [6];

    seg_dynamic #(.CNT_MAX(16'(CNT))) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .price     (price),
        .point     (point),
        .seg_en    (seg_en),
        .sign      (sign),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 sys_clk = ~sys_clk;

    // Clock edges seen since the last reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    function automatic logic [7:0] glyph_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected segment byte for digit position i, from decimal arithmetic.
    function automatic logic [7:0] model_seg(input int unsigned v, input logic sg,
                                             input logic [5:0] pt, input int i);
        int unsigned d [6];
        int h;
        logic [7:0] g;
        if (v > 999999) v = 999999;
        h = 0;
        for (int k = 0; k < 6; k++) begin
            d[k] = (v / (10 ** k)) % 10;
            if (d[k] != 0) h = k;
        end
        if (i <= h)                   g = glyph_of(int'(d[i]));
        else if (sg && (i == h + 1))  g = 8'hBF;
        else                          g = 8'hFF;
        if (pt[i]) g[7] = 1'b0;
        return g;
    endfunction

    // Expected sel k edges after reset release, when enabled.
    function automatic logic [5:0] model_sel(input int k);
        return 6'b000001 << (((k - 1) / DWELL) % 6);
    endfunction

    // Observe one full refresh and record the byte shown for each selected digit.
    task automatic capture();
        obs_seen = '0;
        for (int i = 0; i < 6; i++) obs_seg[i] = 8'hxx;
        for (int c = 0; c < 6 * DWELL + 6; c++) begin
            @(negedge sys_clk);
            for (int i = 0; i < 6; i++) begin
                if (sel === (6'b000001 << i)) begin
                    obs_seg[i]  = seg;
                    obs_seen[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic settle();
        repeat (50) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        price = 20'd0; point = 6'b0; seg_en = 1'b1; sign = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (sel !== 6'b000000) begin errors++; $display("FAIL reset_sel got %b want 000000", sel); end
        checks++;
        if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", seg); end
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge sys_clk);
            checks++;
            if (sel !== model_sel(k)) begin
                errors++; $display("FAIL scan_sel k=%0d got %b want %b", k, sel, model_sel(k));
            end
            checks++;
            if (seg !== model_seg(0, 1'b0, 6'b0, ((k - 1) / DWELL) % 6)) begin
                errors++; $display("FAIL scan_seg k=%0d got %h want %h", k, seg,
                                   model_seg(0, 1'b0, 6'b0, ((k - 1) / DWELL) % 6));
            end
        end
    endtask

    task automatic test_simple();
        price = 20'd12; point = 6'b0; sign = 1'b0; seg_en = 1'b1;
        settle();
        capture();
        exp_tab = '{8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        checks++;
        if (obs_seen !== 6'h3F) begin errors++; $display("FAIL simple_seen got %b want 111111", obs_seen); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_seg[i] !== exp_tab[i]) begin
                errors++; $display("FAIL simple_d%0d got %h want %h", i, obs_seg[i], exp_tab[i]);
            end
        end
    endtask

    task automatic test_zero();
        price = 20'd0;
        settle();
        capture();
        exp_tab = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_seg[i] !== exp_tab[i]) begin
                errors++; $display("FAIL zero_d%0d got %h want %h", i, obs_seg[i], exp_tab[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [19:0] vals [2];
        vals = '{20'd999_999, 20'hFFFFF};
        for (int t = 0; t < 2; t++) begin
            price = vals[t];
            settle();
            capture();
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_seg[i] !== 8'h90) begin
                    errors++; $display("FAIL sat_%h_d%0d got %h want 90", vals[t], i, obs_seg[i]);
                end
            end
        end
    endtask

    task automatic test_sign_point();
        price = 20'd34; sign = 1'b1; point = 6'b000010;
        settle();
        capture();
        exp_tab = '{8'h99, 8'h30, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_seg[i] !== exp_tab[i]) begin
                errors++; $display("FAIL signpt_d%0d got %h want %h", i, obs_seg[i], exp_tab[i]);
            end
        end
        price = 20'd123456; point = 6'b0;
        settle();
        capture();
        exp_tab = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_seg[i] !== exp_tab[i]) begin
                errors++; $display("FAIL fullsign_d%0d got %h want %h", i, obs_seg[i], exp_tab[i]);
            end
        end
    endtask

    task automatic test_disable();
        int idx;
        // Land partway through a dwell before turning the display off.
        while ((cyc % DWELL) != 2) @(negedge sys_clk);
        seg_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge sys_clk);
            checks++;
            if (sel !== 6'b000000 || seg !== 8'hFF) begin
                errors++; $display("FAIL disable c=%0d got sel=%b seg=%h want 000000/ff", c, sel, seg);
            end
        end
        seg_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge sys_clk);
            idx = ((cyc - 1) / DWELL) % 6;
            checks++;
            if (sel !== model_sel(cyc)) begin
                errors++; $display("FAIL reenable_sel c=%0d got %b want %b", c, sel, model_sel(cyc));
            end
            checks++;
            if (seg !== model_seg(price, sign, point, idx)) begin
                errors++; $display("FAIL reenable_seg c=%0d got %h want %h", c, seg,
                                   model_seg(price, sign, point, idx));
            end
        end
    endtask

    task automatic test_reset_mid();
        price = 20'd777; sign = 1'b0; point = 6'b0; seg_en = 1'b1;
        settle();
        // Passes start with LOAD on edge 2, 24, ...; stop inside the shift phase.
        while (((cyc - 2) % 22) != 10) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 6'b000000 || seg !== 8'hFF) begin
            errors++; $display("FAIL midreset got sel=%b seg=%h want 000000/ff", sel, seg);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (sel !== 6'b000001 || seg !== 8'hC0) begin
            errors++; $display("FAIL postreset_first got sel=%b seg=%h want 000001/c0", sel, seg);
        end
        repeat (43) @(negedge sys_clk);
        capture();
        exp_tab = '{8'hF8, 8'hF8, 8'hF8, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_seg[i] !== exp_tab[i]) begin
                errors++; $display("FAIL postreset_d%0d got %h want %h", i, obs_seg[i], exp_tab[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 3))
                0:       price = 20'($urandom_range(0, 99));
                1:       price = 20'($urandom_range(100, 9999));
                2:       price = 20'($urandom_range(10000, 999999));
                default: price = 20'($urandom_range(999999, 1048575));
            endcase
            sign  = 1'($urandom_range(0, 1));
            point = 6'($urandom);
            settle();
            capture();
            checks++;
            if (obs_seen !== 6'h3F) begin errors++; $display("FAIL rand%0d_seen got %b want 111111", t, obs_seen); end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_seg[i] !== model_seg(price, sign, point, i)) begin
                    errors++; $display("FAIL rand%0d_d%0d price=%0d sign=%0d point=%b got %h want %h",
                                       t, i, price, sign, point, obs_seg[i],
                                       model_seg(price, sign, point, i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_zero();
        test_saturation();
        test_sign_point();
        test_disable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_dynamic.md
# seg_dynamic

Display back-end for the taxi meter. It consumes the fare word and the display qualifiers (`price`, `point`, `seg_en`, `sign`) driven by the meter's fare-generation block. It converts the binary fare to six BCD digits with a sequential double-dabble engine, then time-multiplexes them onto a six-digit common-anode 7-segment module. Leading zeros are blanked, and an optional minus sign and per-digit decimal points are supported.

## Interface
- `CNT_MAX`, default 16'd49_999: scan-tick divider terminal count; 1 ms per digit at 50 MHz.
- `sys_clk`, in, 1: system clock, 50 MHz.
- `sys_rst_n`, in, 1: reset, asynchronous assert, active-low.
- `price`, in, 20: unsigned binary value to display.
- `point`, in, 6: decimal point enables; bit i lights the dp of digit i; active high.
- `seg_en`, in, 1: display enable, active high.
- `sign`, in, 1: when high, show a minus sign.
- `sel`, out, 6: digit select, one-hot, active high; bit 0 is the rightmost digit, bit 5 the leftmost.
- `seg`, out, 8: segment drive, active low, bit order {dp,g,f,e,d,c,b,a}.

## Operation
- Saturation: if `price` > 999_999, the converter uses 999_999.
- BCD converter: a free-running FSM with states IDLE → LOAD → SHIFT → DONE → LOAD …
  - LOAD: samples the saturated `price` into a 20-bit shift register and clears the 24-bit BCD accumulator.
  - SHIFT: runs exactly 20 cycles. Each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left by 1.
  - DONE: copies the accumulator into the 24-bit display register `disp_bcd`, then returns to LOAD.
  - IDLE is the post-reset state only; it exits to LOAD on the first clock.
- One conversion pass is 22 cycles. A change on `price` mid-pass is ignored until the next LOAD.
- Blanking: let h be the index of the highest nonzero digit of `disp_bcd`, with h = 0 if the value is 0.
  - Digits above h are blank (8'hFF).
  - Digit 0 is always shown, so 0 displays as "0".
- Sign: when `sign` = 1 and h < 5, digit h+1 shows minus (8'hBF, g lit only). When h = 5, the sign is dropped.
- Glyphs, active low:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
  - blank = FF
- Decimal point: if `point[i]` = 1, `seg[7]` is cleared while digit i is selected. This applies even to blank or minus digits.
- Scan:
  - A 16-bit counter counts 0..CNT_MAX and wraps. The wrap cycle is a scan tick.
  - On each tick, digit index `idx` advances 0→1→…→5→0.
- Output stage:
  - `sel` and `seg` are registered and updated in the cycle after `idx` changes, so `sel` and `seg` always change together.
  - `sel` = 1<<idx.
  - `seg` is the glyph of digit idx, computed from `disp_bcd`, `sign` and `point`.
- Disable: while `seg_en` = 0, `sel` = 6'b000000 and `seg` = 8'hFF. The scan counter and converter keep running.

## Timing
- Reset values:
  - `sel` = 6'b000000, `seg` = 8'hFF.
  - `disp_bcd` = 0, `idx` = 0, scan counter = 0, FSM = IDLE.
- Reset asserted mid-scan or mid-conversion returns everything to the reset values immediately (asynchronous). Release restarts from IDLE.
- Price-to-display latency is at most 44 cycles: a worst case of one full pass in progress plus one full pass.
- Digit dwell is CNT_MAX+1 cycles. The full refresh period is 6·(CNT_MAX+1) cycles.
- `sign`, `point` and `seg_en` are sampled each cycle by the output stage, so each takes effect within 1 cycle.
- `disp_bcd` updates only in DONE, so a digit never shows a partially converted value.

## Test plan
All scenarios use CNT_MAX = 4 in simulation.
- **Simple value:** `price` = 12, `seg_en` = 1, others 0; wait 50 cycles.
  - Required: idx0 → `seg` = A4 with `sel` = 000001; idx1 → F9 with `sel` = 000010; idx2..5 → FF.
- **Zero:** `price` = 0.
  - Required: idx0 → C0; all other digits FF.
- **Full range and saturation:** `price` = 999_999, then `price` = 20'hFFFFF.
  - Required: in both cases all six digits are 90.
- **Sign and point:** `price` = 34, `sign` = 1, `point` = 6'b000010.
  - Required: idx0 → 99; idx1 → 30 (3 with dp); idx2 → BF; idx3..5 → FF.
  - Then set `price` = 123456 with `sign` = 1. Required: no minus shown; digits read 1,2,3,4,5,6 from idx5 down to idx0.
- **Disable:** set `seg_en` = 0 mid-scan.
  - Required: next cycle `sel` = 000000, `seg` = FF.
  - Re-enable. Required: the scan resumes at the current `idx` with no glitch.
- **Reset mid-conversion:** `price` = 777 set; assert `sys_rst_n` low during SHIFT.
  - Required: `sel` = 0 and `seg` = FF immediately.
  - After release and 44 cycles, the display reads 7,7,7 on idx2..0.
